// File: rtl/yacht_pkg.sv
// Shared definitions for the Yacht Dice keypad path: key codes, press FSM
// states, matrix geometry and small bit-map helpers.
package yacht_pkg;

    localparam int SCAN_COLS = 4;
    localparam int SCAN_ROWS = 4;
    localparam int MAP_W     = SCAN_COLS * SCAN_ROWS;

    localparam logic [3:0] KEY_ROLL    = 4'd0;
    localparam logic [3:0] KEY_HOLD_0  = 4'd1;
    localparam logic [3:0] KEY_HOLD_1  = 4'd2;
    localparam logic [3:0] KEY_HOLD_2  = 4'd3;
    localparam logic [3:0] KEY_HOLD_3  = 4'd4;
    localparam logic [3:0] KEY_HOLD_4  = 4'd5;
    localparam logic [3:0] KEY_SEL_UP  = 4'd6;
    localparam logic [3:0] KEY_SEL_DN  = 4'd7;
    localparam logic [3:0] KEY_CONFIRM = 4'd8;

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } press_state_e;

    // Position of the set bit in a one-hot map, i.e. col*4 + row.
    function automatic logic [3:0] key_index(input logic [MAP_W-1:0] map);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < MAP_W; i++) begin
            if (map[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic two_or_more(input logic [MAP_W-1:0] map);
        return (map & (map - 16'd1)) != 16'h0000;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and event-side signals of the scanner, bundled for the game board.
interface keypad_scanner_if;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic       multi_key;

    modport master (
        output key_row,
        input  key_col,
        input  key_valid,
        input  key_code,
        input  key_held,
        input  multi_key
    );

    modport slave (
        input  key_row,
        output key_col,
        output key_valid,
        output key_code,
        output key_held,
        output multi_key
    );
endinterface

// File: rtl/matrix_debounce.sv
// Whole-matrix debouncer: accepts a new key map only after DEBOUNCE_FRAMES
// identical consecutive frames.
module matrix_debounce
    import yacht_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_valid_i,
    input  logic [MAP_W-1:0] frame_i,
    output logic [MAP_W-1:0] deb_map_o
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES - 1);

    logic [MAP_W-1:0] prev_frame_q, prev_frame_d;
    logic [MAP_W-1:0] deb_map_q, deb_map_d;
    logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;

    // Frame comparison, saturating stability count and map acceptance.
    always_comb begin
        prev_frame_d = prev_frame_q;
        stable_cnt_d = stable_cnt_q;
        deb_map_d    = deb_map_q;
        if (frame_valid_i) begin
            prev_frame_d = frame_i;
            if (frame_i == prev_frame_q) begin
                if (stable_cnt_q != CNT_MAX) begin
                    stable_cnt_d = stable_cnt_q + CNT_W'(1);
                end else begin
                    stable_cnt_d = stable_cnt_q;
                end
            end else begin
                stable_cnt_d = '0;
            end
            if (stable_cnt_d == CNT_MAX) begin
                deb_map_d = frame_i;
            end else begin
                deb_map_d = deb_map_q;
            end
        end else begin
            deb_map_d = deb_map_q;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_frame_q <= '0;
            stable_cnt_q <= '0;
            deb_map_q    <= '0;
        end else begin
            prev_frame_q <= prev_frame_d;
            stable_cnt_q <= stable_cnt_d;
            deb_map_q    <= deb_map_d;
        end
    end

    assign deb_map_o = deb_map_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column multiplexing, row sampling, debounce and
// single-key press event generation for the game FSM.
module keypad_scanner
    import yacht_pkg::*;
#(
    parameter int SCAN_DIV_W      = 14,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.slave   kp
);

    logic [SCAN_DIV_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [1:0]            col_idx_q, col_idx_d;
    logic [3:0]            key_col_q, key_col_d;
    logic [MAP_W-1:0]      raw_map_q, raw_map_d;
    logic                  frame_done_q, frame_done_d;
    logic                  dwell_end_s;
    logic [MAP_W-1:0]      deb_map_s;

    press_state_e          state_q;
    logic                  key_valid_q;
    logic [3:0]            key_code_q;
    logic                  key_held_q;
    logic                  multi_key_q;

    assign dwell_end_s = &dwell_cnt_q;

    // Next-state logic for the scan counter, column drive and raw sampling.
    always_comb begin
        dwell_cnt_d  = dwell_cnt_q + SCAN_DIV_W'(1);
        raw_map_d    = raw_map_q;
        frame_done_d = 1'b0;
        if (dwell_end_s) begin
            col_idx_d = col_idx_q + 2'd1;
            // Rows read at the very end of the dwell, after a full settle time.
            raw_map_d[{col_idx_q, 2'b00} +: 4] = ~kp.key_row;
            frame_done_d = (col_idx_q == 2'(SCAN_COLS - 1));
        end else begin
            col_idx_d = col_idx_q;
        end
        key_col_d = ~(4'b0001 << col_idx_d);
    end

    // Scan and sampling registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_cnt_q  <= '0;
            col_idx_q    <= 2'd0;
            key_col_q    <= 4'b1110;
            raw_map_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            dwell_cnt_q  <= dwell_cnt_d;
            col_idx_q    <= col_idx_d;
            key_col_q    <= key_col_d;
            raw_map_q    <= raw_map_d;
            frame_done_q <= frame_done_d;
        end
    end

    matrix_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk           (clk),
        .reset         (reset),
        .frame_valid_i (frame_done_q),
        .frame_i       (raw_map_q),
        .deb_map_o     (deb_map_s)
    );

    // Press FSM: one event per press, only for a clean single-key map.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RELEASED;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            key_held_q  <= 1'b0;
            multi_key_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            key_held_q  <= |deb_map_s;
            multi_key_q <= two_or_more(deb_map_s);
            case (state_q)
                ST_RELEASED: begin
                    if (deb_map_s != 16'h0000) begin
                        state_q <= ST_PRESSED;
                        if (!two_or_more(deb_map_s)) begin
                            key_valid_q <= 1'b1;
                            key_code_q  <= key_index(deb_map_s);
                        end else begin
                            key_code_q  <= key_code_q;
                        end
                    end else begin
                        state_q <= ST_RELEASED;
                    end
                end
                ST_PRESSED: begin
                    if (deb_map_s == 16'h0000) begin
                        state_q <= ST_RELEASED;
                    end else begin
                        state_q <= ST_PRESSED;
                    end
                end
                default: begin
                    state_q <= ST_RELEASED;
                end
            endcase
        end
    end

    assign kp.key_col   = key_col_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_held  = key_held_q;
    assign kp.multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical key-matrix model, a
// frame-level behavioural reference checked every cycle, and directed scenarios.
module tb_keypad_scanner;
    import yacht_pkg::*;

    localparam int SDW = 2;
    localparam int DF  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys_r = 16'h0000;
    logic [3:0]  row_s;
    int          checks = 0;
    int          errors = 0;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV_W      (SDW),
        .DEBOUNCE_FRAMES (DF)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .kp    (kif)
    );

    always #5 clk = ~clk;

    // Physical matrix: a closed key pulls its row low while its column is driven.
    always_comb begin
        row_s = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!kif.key_col[c]) row_s = row_s & ~keys_r[c*4 +: 4];
        end
    end
    assign kif.key_row = row_s;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    int          e = 0;
    int          col_m;
    int          hcnt = 0;
    logic [15:0] hist [DF];
    logic [15:0] cur_frame = 16'h0;
    logic [15:0] deb_m = 16'h0;
    bit          pressed = 0;
    bit          stable;
    bit          pend = 0;
    int          pend_edge = 0;
    bit          pend_pulse;
    logic [3:0]  pend_code;
    bit          pend_held, pend_multi;
    logic        exp_valid = 1'b0;
    logic [3:0]  exp_code = 4'd0;
    logic        exp_held = 1'b0;
    logic        exp_multi = 1'b0;
    logic [3:0]  exp_col = 4'b1110;
    int          pulse_cnt = 0;
    logic [3:0]  last_code = 4'd0;

    function automatic logic [3:0] bit_pos(input logic [15:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 16; i++) if (m[i]) r = 4'(i);
        return r;
    endfunction

    initial begin : model
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                e = 0; hcnt = 0; cur_frame = 16'h0; deb_m = 16'h0; pressed = 0; pend = 0;
                exp_valid = 1'b0; exp_code = 4'd0; exp_held = 1'b0; exp_multi = 1'b0;
            end else begin
                e++;
                exp_valid = 1'b0;
                if (pend && e == pend_edge) begin
                    exp_valid = pend_pulse;
                    if (pend_pulse) exp_code = pend_code;
                    exp_held  = pend_held;
                    exp_multi = pend_multi;
                    pend = 0;
                end
                if (e % 4 == 0) begin
                    col_m = ((e - 1) / 4) % 4;
                    cur_frame[col_m*4 +: 4] = keys_r[col_m*4 +: 4];
                    if (col_m == 3) begin
                        for (int i = DF - 1; i > 0; i--) hist[i] = hist[i-1];
                        hist[0] = cur_frame;
                        if (hcnt < DF) hcnt++;
                        stable = (hcnt == DF);
                        for (int i = 1; i < DF; i++) if (hist[i] != hist[0]) stable = 0;
                        if (stable) deb_m = hist[0];
                        pend = 1; pend_edge = e + 2; pend_pulse = 0; pend_code = 4'd0;
                        if (!pressed && deb_m != 16'h0) begin
                            pressed = 1;
                            if ($countones(deb_m) == 1) begin
                                pend_pulse = 1;
                                pend_code  = bit_pos(deb_m);
                            end
                        end else if (pressed && deb_m == 16'h0) begin
                            pressed = 0;
                        end
                        pend_held  = (deb_m != 16'h0);
                        pend_multi = ($countones(deb_m) >= 2);
                    end
                end
            end
            exp_col = ~(4'b0001 << ((e / 4) % 4));
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            check("key_col",   {12'h0, kif.key_col},   {12'h0, exp_col});
            check("key_valid", {15'h0, kif.key_valid}, {15'h0, exp_valid});
            check("key_code",  {12'h0, kif.key_code},  {12'h0, exp_code});
            check("key_held",  {15'h0, kif.key_held},  {15'h0, exp_held});
            check("multi_key", {15'h0, kif.multi_key}, {15'h0, exp_multi});
            if (kif.key_valid === 1'b1) begin
                pulse_cnt++;
                last_code = kif.key_code;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_col"},   {12'h0, kif.key_col},   16'h000E);
        check({tag, "_valid"}, {15'h0, kif.key_valid}, 16'h0000);
        check({tag, "_code"},  {12'h0, kif.key_code},  16'h0000);
        check({tag, "_held"},  {15'h0, kif.key_held},  16'h0000);
        check({tag, "_multi"}, {15'h0, kif.multi_key}, 16'h0000);
    endtask

    logic [3:0] col_tab [16] = '{4'hE, 4'hE, 4'hE, 4'hD, 4'hD, 4'hD, 4'hD, 4'hB,
                                 4'hB, 4'hB, 4'hB, 4'h7, 4'h7, 4'h7, 4'h7, 4'hE};
    int p0;
    int lat;
    bit found;

    initial begin : stimulus
        rst = 1'b1; keys_r = 16'h0000;
        step(3);
        check_reset_state("por");

        // Scenario 1: column walk, then a mid-run reset.
        rst = 1'b0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            check("s1_colwalk", {12'h0, kif.key_col}, {12'h0, col_tab[n]});
        end
        step(21);
        rst = 1'b1;
        #1;
        check_reset_state("s1_rst");
        step(2);
        rst = 1'b0;
        step(32);

        // Scenario 2: key 9 (col 2, row 1) held for 5 frames.
        p0 = pulse_cnt;
        keys_r = 16'h0200;
        step(80);
        check("s2_pulses", 16'(pulse_cnt - p0), 16'd1);
        check("s2_code",   {12'h0, last_code}, 16'd9);
        check("s2_held",   {15'h0, kif.key_held}, 16'd1);
        check("s2_multi",  {15'h0, kif.multi_key}, 16'd0);
        keys_r = 16'h0000;
        step(64);

        // Scenario 3: chattering closure on alternate frames.
        p0 = pulse_cnt;
        for (int k = 0; k < 3; k++) begin
            keys_r = 16'h0200; step(16);
            keys_r = 16'h0000; step(16);
        end
        check("s3_pulses", 16'(pulse_cnt - p0), 16'd0);
        check("s3_held",   {15'h0, kif.key_held}, 16'd0);
        step(32);

        // Scenario 4: keys 0+5, partial release, full release, then key 3.
        p0 = pulse_cnt;
        keys_r = 16'h0021; step(80);
        check("s4_pulses_multi", 16'(pulse_cnt - p0), 16'd0);
        check("s4_multi",        {15'h0, kif.multi_key}, 16'd1);
        keys_r = 16'h0001; step(80);
        check("s4_pulses_part",  16'(pulse_cnt - p0), 16'd0);
        check("s4_held_part",    {15'h0, kif.key_held}, 16'd1);
        keys_r = 16'h0000; step(64);
        keys_r = 16'h0008; step(80);
        check("s4_pulses_k3",    16'(pulse_cnt - p0), 16'd1);
        check("s4_code",         {12'h0, last_code}, 16'd3);
        keys_r = 16'h0000; step(64);

        // Scenario 5: roll from key 7 to key 8, release, press 8.
        p0 = pulse_cnt;
        keys_r = 16'h0080; step(80);
        keys_r = 16'h0100; step(80);
        check("s5_pulses_roll", 16'(pulse_cnt - p0), 16'd1);
        check("s5_code_roll",   {12'h0, last_code}, 16'd7);
        keys_r = 16'h0000; step(64);
        keys_r = 16'h0100; step(80);
        check("s5_pulses_k8",   16'(pulse_cnt - p0), 16'd2);
        check("s5_code_k8",     {12'h0, last_code}, 16'd8);
        keys_r = 16'h0000; step(64);

        // Scenario 6: reset while key 4 is held, key still held afterwards.
        keys_r = 16'h0010; step(80);
        rst = 1'b1;
        #1;
        check_reset_state("s6_rst");
        step(2);
        rst = 1'b0;
        lat = 0; found = 0;
        for (int n = 1; n <= 200 && !found; n++) begin
            @(negedge clk);
            if (kif.key_valid === 1'b1) begin
                found = 1;
                lat = n;
            end
        end
        check("s6_latency", 16'(lat), 16'd50);
        check("s6_code",    {12'h0, kif.key_code}, 16'd4);
        #2;
        keys_r = 16'h0000;
        step(64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad input block for the Yacht Dice board: the input-side counterpart of the multiplexed 7-segment driver. It time-multiplexes an active-low one-hot column drive across a 4x4 key matrix and samples the active-low row lines at the end of each column dwell. It debounces whole-matrix snapshots and delivers single-key press events, as a one-cycle valid pulse plus a 4-bit key code, to the game FSM.

## Interface
- SCAN_DIV_W, default 14: column dwell is 2**SCAN_DIV_W clk cycles.
- DEBOUNCE_FRAMES, default 4: number of identical consecutive full-matrix frames required to accept a new key map. Minimum 2.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- key_row  in  4  row sense lines, active-low (0 = key closed on the driven column). Externally pulled up.
- key_col  out  4  column drive, active-low one-hot.
- key_valid  out  1  one-cycle pulse per accepted single-key press.
- key_code  out  4  code of the accepted key, = col*4 + row. Holds its value until the next key_valid.
- key_held  out  1  level; high while the debounced map is non-zero.
- multi_key  out  1  level; high while the debounced map has 2 or more bits set.

## Operation
- Scan counter: dwell_cnt (SCAN_DIV_W bits) and col_idx (2 bits). dwell_cnt increments every cycle. On wrap, col_idx increments mod 4.
- key_col is driven as ~(1 << col_idx), registered.
- Sampling: when dwell_cnt is all ones, ~key_row is written into the 4 bits of raw_map for col_idx (bits col_idx*4 + row). Sampling at the end of the dwell gives the matrix a full dwell to settle.
- Frame end: the sample taken with col_idx == 3 completes a 16-bit frame.
- Debounce, evaluated on the cycle after frame end:
  - If frame == prev_frame, stable_cnt saturates upward.
  - Otherwise stable_cnt = 0.
  - prev_frame <= frame in both cases.
  - When stable_cnt reaches DEBOUNCE_FRAMES-1, deb_map <= frame.
- Press FSM, two states:
  - RELEASED: when deb_map becomes non-zero with exactly one bit set, assert key_valid, load key_code, and go to PRESSED. When deb_map becomes non-zero with 2 or more bits set, go to PRESSED with no event.
  - PRESSED: stay until deb_map == 0, then go to RELEASED. No events are generated in PRESSED.
- One key per press. Rolling from key A to key B without a full release gives no event for B. A multi-key press followed by a partial release gives no event until a full release.
- key_held = |deb_map. multi_key = popcount(deb_map) >= 2. Both are registered.

## Timing
- Reset values:
  - key_col = 4'b1110.
  - dwell_cnt, col_idx, raw_map, prev_frame, stable_cnt, deb_map = 0.
  - FSM = RELEASED.
  - key_valid = 0, key_code = 0, key_held = 0, multi_key = 0.
- Frame period is 4 * 2**SCAN_DIV_W cycles.
- Latency: key_valid rises exactly 2 cycles after the final (col 3) sample of the frame that satisfies debounce. Minimum press-to-event time is DEBOUNCE_FRAMES frames plus 2 cycles.
- key_valid is high for exactly 1 cycle. key_code is valid in the same cycle.
- A change anywhere in the matrix mid-frame corrupts only that frame: stable_cnt resets and the old deb_map is retained.
- Asynchronous reset mid-frame or mid-press returns to the reset state immediately. A key still held after reset release must be debounced afresh and then produces a normal event.
- stable_cnt saturates and never wraps.

## Structure
- Shared package `yacht_pkg` holds:
  - the key code localparams (KEY_ROLL, KEY_HOLD_0..4, KEY_SEL_UP/DN, KEY_CONFIRM as 4-bit codes);
  - the FSM state enum;
  - the scan column count (4).
- One natural sub-module, `matrix_debounce`: frame compare, stable_cnt and deb_map. The top level keeps the scan counter, column drive and press FSM.

## Test plan
All scenarios use SCAN_DIV_W=2 (4-cycle dwell, 16-cycle frame) and DEBOUNCE_FRAMES=3.

1. Assert reset mid-run with key_row=4'hF -> key_col=4'b1110, all outputs 0. Release reset -> key_col steps through 1110, 1101, 1011, 0111, changing every 4 cycles.
2. Close key (col 2, row 1), modelled by driving key_row=4'b1101 only while key_col=4'b1011, held for 5 frames -> exactly one key_valid pulse with key_code=9. key_held=1 thereafter. multi_key=0.
3. Scenario 2 with the press present for 1 frame only and the closure chattering on alternate frames -> no key_valid, key_held=0.
4. Keys 0 and 5 closed together -> no key_valid, multi_key=1. Release key 5 only -> still no event. Release all, then press key 3 -> key_valid with key_code=3.
5. Hold key 7, then roll to key 8 without releasing -> one event (code 7) only. Release, then press 8 -> event with code 8.
6. Assert reset while key 4 is held in PRESSED. Deassert reset with key 4 still held -> after 3 stable frames, key_valid with key_code=4.
